// File: rtl/bm_dl_bcd_7seg_scan_driver.sv
// rtl/bm_dl_bcd_7seg_scan_driver.sv - time-multiplexed BCD to seven-segment scan driver
// Double-buffered digits swap only at frame boundaries; outputs lag the scan index by one clock.
module bm_dl_bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [1:7]              leds,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pre_cnt_q, pre_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d, shw_bcd_q, shw_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, shw_dp_q, shw_dp_d;
  logic                    pend_v_q, pend_v_d;
  logic [6:0]              leds_q, leds_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    pre_end, boundary, zero_run, cur_dp, cur_blank;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   en;
  logic [6:0]              seg;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    idx_d      = idx_q;
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    shw_bcd_d  = shw_bcd_q;
    shw_dp_d   = shw_dp_q;

    pre_end  = (pre_cnt_q == PRE_LAST);
    boundary = pre_end && (idx_q == IDX_LAST);

    pre_cnt_d = pre_end ? '0 : pre_cnt_q + PW'(1);
    if (pre_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    if (boundary && pend_v_q) begin
      shw_bcd_d = pend_bcd_q;
      shw_dp_d  = pend_dp_q;
      pend_v_d  = 1'b0;
    end

    // A load landing on the boundary edge bypasses the pending buffer so the newest value wins.
    if (load) begin
      if (boundary) begin
        shw_bcd_d = bcd_in;
        shw_dp_d  = dp_in;
        pend_v_d  = 1'b0;
      end else begin
        pend_bcd_d = bcd_in;
        pend_dp_d  = dp_in;
        pend_v_d   = 1'b1;
      end
    end

    zero_run  = 1'b1;
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    en        = '0;
    // Walk from the most significant digit so zero_run means "this digit and all above are zero".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shw_bcd_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_digit = shw_bcd_q[4*i +: 4];
        cur_dp    = shw_dp_q[i];
        cur_blank = (BLANK_LZ != 0) && (i > 0) && zero_run;
        en[i]     = 1'b1;
      end
    end

    seg          = cur_blank ? 7'b0000000 : seg7(cur_digit);
    leds_d       = seg ^ {7{INV}};
    dp_d         = cur_dp ^ INV;
    digit_en_d   = en ^ {NUM_DIGITS{INV}};
    frame_done_d = boundary;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_q    <= '0;
      idx_q        <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_v_q     <= 1'b0;
      shw_bcd_q    <= '0;
      shw_dp_q     <= '0;
      leds_q       <= {7{INV}};
      dp_q         <= INV;
      digit_en_q   <= {NUM_DIGITS{INV}};
      frame_done_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      idx_q        <= idx_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      pend_v_q     <= pend_v_d;
      shw_bcd_q    <= shw_bcd_d;
      shw_dp_q     <= shw_dp_d;
      leds_q       <= leds_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign leds       = leds_q;
  assign dp         = dp_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bm_dl_bcd_7seg_scan_driver.sv
// tb/tb_bm_dl_bcd_7seg_scan_driver.sv - scoreboard bench for the 7-segment scan driver
// Three instances share stimulus: default, no leading-zero blanking, and active-low outputs.
module tb_bm_dl_bcd_7seg_scan_driver;

  logic        clock;
  logic        reset;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;

  logic [1:7]  leds0, leds1, leds2;
  logic        dp0, dp1, dp2;
  logic [3:0]  en0, en1, en2;
  logic        fd0, fd1, fd2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] l0;
    logic [6:0] l1;
    logic [6:0] l2;
    logic       dpe;
    logic       fd;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] nxt_bcd;
  logic [3:0]  nxt_dp;
  int          frame_no = 0;

  localparam logic [6:0] SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  bm_dl_bcd_7seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(0), .BLANK_LZ(1)) dut (
    .clock(clock), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .leds(leds0), .dp(dp0), .digit_en(en0), .frame_done(fd0));

  bm_dl_bcd_7seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(0), .BLANK_LZ(0)) dut_nb (
    .clock(clock), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .leds(leds1), .dp(dp1), .digit_en(en1), .frame_done(fd1));

  bm_dl_bcd_7seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_al (
    .clock(clock), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .leds(leds2), .dp(dp2), .digit_en(en2), .frame_done(fd2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i, input bit blz);
    logic [15:0] sh;
    sh = v >> (4 * i);
    if (blz && i > 0 && sh == 16'h0) return 7'b0000000;
    return SEG[sh[3:0]];
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    exp_t e;
    for (int k = 1; k <= 16; k++) begin
      int i;
      i     = (k - 1) / 4;
      e.en  = 4'b0001 << i;
      e.l0  = exp_seg(v, i, 1'b1);
      e.l1  = exp_seg(v, i, 1'b0);
      e.l2  = ~exp_seg(v, i, 1'b1);
      e.dpe = d[i];
      e.fd  = (k == 16);
      sb.push_back(e);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " leds"},  {9'b0, leds0}, 16'h0000);
    chk({tag, " dp"},    {15'b0, dp0},  16'h0000);
    chk({tag, " en"},    {12'b0, en0},  16'h0000);
    chk({tag, " fd"},    {15'b0, fd0},  16'h0000);
    chk({tag, " nb_leds"}, {9'b0, leds1}, 16'h0000);
    chk({tag, " al_leds"}, {9'b0, leds2}, 16'h007f);
    chk({tag, " al_dp"},   {15'b0, dp2},  16'h0001);
    chk({tag, " al_en"},   {12'b0, en2},  16'h000f);
    chk({tag, " al_fd"},   {15'b0, fd2},  16'h0000);
  endtask

  task automatic drive(input int k, input int la, input logic [15:0] va, input logic [3:0] da,
                       input int lb, input logic [15:0] vb, input logic [3:0] db);
    load = 1'b0;
    if (k == la) begin
      load = 1'b1; bcd_in = va; dp_in = da; nxt_bcd = va; nxt_dp = da;
    end
    if (k == lb) begin
      load = 1'b1; bcd_in = vb; dp_in = db; nxt_bcd = vb; nxt_dp = db;
    end
  endtask

  // Starts in the cycle right after a boundary (or reset) edge; cycle 16 is the frame_done cycle.
  task automatic run_frame(input int n, input int la, input logic [15:0] va, input logic [3:0] da,
                           input int lb, input logic [15:0] vb, input logic [3:0] db);
    exp_t  e;
    string t;
    drive(0, la, va, da, lb, vb, db);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      t = $sformatf("f%0d c%0d", frame_no, k);
      if (sb.size() == 0) begin
        chk({t, " sb_empty"}, 16'h0001, 16'h0000);
      end else begin
        e = sb.pop_front();
        chk({t, " en"},      {12'b0, en0},   {12'b0, e.en});
        chk({t, " leds"},    {9'b0, leds0},  {9'b0, e.l0});
        chk({t, " dp"},      {15'b0, dp0},   {15'b0, e.dpe});
        chk({t, " fd"},      {15'b0, fd0},   {15'b0, e.fd});
        chk({t, " nb_leds"}, {9'b0, leds1},  {9'b0, e.l1});
        chk({t, " nb_en"},   {12'b0, en1},   {12'b0, e.en});
        chk({t, " al_en"},   {12'b0, en2},   {12'b0, ~e.en});
        chk({t, " al_leds"}, {9'b0, leds2},  {9'b0, e.l2});
        chk({t, " al_dp"},   {15'b0, dp2},   {15'b0, ~e.dpe});
        chk({t, " al_fd"},   {15'b0, fd2},   {15'b0, e.fd});
      end
      drive(k, la, va, da, lb, vb, db);
    end
    if (n == 16) push_frame(nxt_bcd, nxt_dp);
    frame_no++;
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    bcd_in  = 16'h0;
    dp_in   = 4'h0;
    nxt_bcd = 16'h0;
    nxt_dp  = 4'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset("reset");
    reset = 1'b0;
    push_frame(16'h0000, 4'b0000);

    run_frame(16, 0,  16'h1234, 4'b0100, -1, 16'h0, 4'h0);
    run_frame(16, 3,  16'h0007, 4'b0000, -1, 16'h0, 4'h0);
    run_frame(16, 10, 16'hFA09, 4'b1000, -1, 16'h0, 4'h0);
    run_frame(16, 6,  16'h5555, 4'b0010, -1, 16'h0, 4'h0);
    run_frame(16, 2,  16'h1111, 4'b1111, 9, 16'h2222, 4'b0001);
    run_frame(16, 15, 16'h0340, 4'b0001, -1, 16'h0, 4'h0);
    run_frame(8,  5,  16'h9876, 4'b1111, -1, 16'h0, 4'h0);

    sb.delete();
    reset = 1'b1;
    @(negedge clock);
    check_reset("midreset");
    reset   = 1'b0;
    nxt_bcd = 16'h0;
    nxt_dp  = 4'h0;
    push_frame(16'h0000, 4'b0000);
    run_frame(16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
